rpn_stack_master: RTL and testbench
===================================

Name: rpn_stack_master

Overview:
- Initiator that drives an 8-deep LIFO stack through its push/pop/data_in/data_out/full/empty interface.
- Consumes a stream of reverse-Polish tokens (operands and operators) over a valid/ready handshake.
- For each operand it pushes the value. For each operator it pops two values, computes the result and pushes it back.
- Sits between the token source (switches/UART decoder) and the stack; it is the master side of that stack interface.

Parameters:
- WIDTH, 4, data width of operands, stack entries and result (must match stack width).

Ports:
- clk  in  1  clock.
- rstN  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous error clear; returns FSM to IDLE.
- tok_valid  in  1  token present.
- tok_ready  out  1  controller can accept a token.
- tok_is_op  in  1  1 = operator token, 0 = operand token.
- tok_val  in  WIDTH  operand value, or opcode (bits [2:0]) when tok_is_op=1.
- stk_push  out  1  push strobe to stack.
- stk_pop  out  1  pop strobe to stack.
- stk_data_in  out  WIDTH  value to push.
- stk_data_out  in  WIDTH  stack registered output.
- stk_full  in  1  stack full.
- stk_empty  in  1  stack empty.
- result  out  WIDTH  last computed result.
- result_valid  out  1  one-cycle pulse when result updates.
- error  out  1  sticky error flag.

Behaviour:
- Reset (rstN low, async): state=IDLE.
  - All outputs 0 except tok_ready=1 (IDLE decode).
  - Internal a, b and token registers cleared.
  - Reset mid-operation aborts immediately; the stack is reset by the same rstN.
- Stack contract relied on:
  - A pop sampled at edge N presents the popped value on stk_data_out after edge N; it is valid throughout cycle N+1.
  - stk_empty/stk_full reflect the updated count after that same edge.
- Strobe discipline:
  - stk_push and stk_pop are registered, one cycle each, never asserted together.
  - Never push while stk_full; never pop while stk_empty.
- States and transitions:
  - IDLE: tok_ready=1. A token is accepted on an edge with tok_valid=1; tok_val/tok_is_op are latched.
    - Operand, stk_full=0 → PUSH.
    - Operand, stk_full=1 → ERR.
    - Operator, opcode valid, stk_empty=0 → POP_B.
    - Operator, opcode valid, stk_empty=1 → ERR; no pop issued.
    - Operator, invalid opcode (5..7) → ERR; no stack access.
  - PUSH: stk_push=1, stk_data_in=latched value → IDLE. An operand takes 2 cycles token-to-token.
  - POP_B: stk_pop=1 → WAIT_B.
  - WAIT_B: b ← stk_data_out.
    - stk_empty=1 → ERR. Underflow; b is discarded and the stack is left empty.
    - Otherwise → POP_A.
  - POP_A: stk_pop=1 → WAIT_A.
  - WAIT_A: a ← stk_data_out; r = a op b → PUSH_R.
  - PUSH_R: stk_push=1, stk_data_in=r, result←r, result_valid=1 → IDLE. An operator takes 6 cycles from acceptance to return to IDLE.
  - ERR: error=1, tok_ready=0, no strobes; held until clr=1, then → IDLE with error=0. clr is ignored in other states.
- Opcodes (a = deeper operand, b = top):
  - 0 ADD a+b
  - 1 SUB a−b
  - 2 AND
  - 3 OR
  - 4 XOR
- Arithmetic wraps modulo 2^WIDTH; no carry/borrow output.
- PUSH_R never sees full, because two pops precede it. No check is performed there.
- tok_ready is low in every state except IDLE; tokens presented then are not consumed.

Test Plan:
1. Reset, then tokens 3, 4, op0 → push strobes carry 3 then 4. In PUSH_R stk_data_in=7, result=7, result_valid pulses once; stack holds one entry 7; error=0.
2. Tokens 5, 9, op1 → result=12 (5−9 mod 16). Then tokens 12, op4 → result=0.
3. Operator op0 on empty stack → error=1 next cycle, stk_pop never asserted, tok_ready=0. Pulse clr → error=0, tok_ready=1.
4. Token 6 then op2 → one pop only, then error=1 with stack empty. Invalid opcode 7 with 2 entries → error=1, no strobes, stack unchanged.
5. Push operands 1..8 (stk_full=1), then 9th operand → error=1 and no 9th push strobe.
6. Assert rstN low during POP_A of a 3+4 ADD → all outputs 0 asynchronously. After release: IDLE, tok_ready=1, no result_valid.

Source files
------------

// File: rtl/rpn_stack_master.sv
// -----------------------------------------------------------------------------
// rpn_stack_master
//
// Reverse-Polish evaluator that drives an external 8-deep LIFO stack as its
// master. Operand tokens are pushed. Operator tokens pop b (top) and then
// a (next). The controller computes a op b and pushes the result back.
//
// Ports
//   clk, rstN      : clock, asynchronous active-low reset
//   clr            : synchronous error clear (only honoured in ERR)
//   tok_valid/tok_ready/tok_is_op/tok_val : token handshake from the source
//   stk_push/stk_pop/stk_data_in          : registered strobes/data to stack
//   stk_data_out/stk_full/stk_empty       : stack registered output and flags
//   result/result_valid                   : last computed value, 1-cycle pulse
//   error                                 : sticky error flag, cleared by clr
//
// Opcodes (tok_val[2:0]): 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR; 5..7 are invalid.
// -----------------------------------------------------------------------------
module rpn_stack_master #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             clr,
    input  logic             tok_valid,
    output logic             tok_ready,
    input  logic             tok_is_op,
    input  logic [WIDTH-1:0] tok_val,
    output logic             stk_push,
    output logic             stk_pop,
    output logic [WIDTH-1:0] stk_data_in,
    input  logic [WIDTH-1:0] stk_data_out,
    input  logic             stk_full,
    input  logic             stk_empty,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PUSH,
        S_POP_B,
        S_WAIT_B,
        S_POP_A,
        S_WAIT_A,
        S_PUSH_R,
        S_ERR
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [2:0]       opcode_reg;

    logic [WIDTH-1:0] a_next;
    logic [WIDTH-1:0] alu_next;
    logic             opcode_ok;

    assign opcode_ok = (tok_val[2:0] <= 3'd4);

    // In WAIT_A the deeper operand is only on stk_data_out this cycle, so the
    // ALU takes it directly instead of waiting for a_reg to be loaded.
    always_comb begin
        a_next = a_reg;
        if (state_reg == S_WAIT_A) begin
            a_next = stk_data_out;
        end
    end

    always_comb begin
        alu_next = '0;
        case (opcode_reg)
            3'd0:    alu_next = a_next + b_reg;
            3'd1:    alu_next = a_next - b_reg;
            3'd2:    alu_next = a_next & b_reg;
            3'd3:    alu_next = a_next | b_reg;
            3'd4:    alu_next = a_next ^ b_reg;
            default: alu_next = '0;
        endcase
    end

    // All outputs are registered. Each transition sets up the outputs of the
    // state being entered, so strobes line up exactly with their state.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_reg    <= S_IDLE;
            a_reg        <= '0;
            b_reg        <= '0;
            opcode_reg   <= '0;
            tok_ready    <= 1'b1;
            stk_push     <= 1'b0;
            stk_pop      <= 1'b0;
            stk_data_in  <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            error        <= 1'b0;
        end else begin
            stk_push     <= 1'b0;
            stk_pop      <= 1'b0;
            result_valid <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (tok_valid) begin
                        tok_ready  <= 1'b0;
                        opcode_reg <= tok_val[2:0];
                        if (!tok_is_op) begin
                            if (stk_full) begin
                                state_reg <= S_ERR;
                                error     <= 1'b1;
                            end else begin
                                state_reg   <= S_PUSH;
                                stk_push    <= 1'b1;
                                stk_data_in <= tok_val;
                            end
                        end else if (!opcode_ok || stk_empty) begin
                            // Bad opcode or nothing to pop: no stack access.
                            state_reg <= S_ERR;
                            error     <= 1'b1;
                        end else begin
                            state_reg <= S_POP_B;
                            stk_pop   <= 1'b1;
                        end
                    end
                end
                S_PUSH: begin
                    state_reg <= S_IDLE;
                    tok_ready <= 1'b1;
                end
                S_POP_B: begin
                    state_reg <= S_WAIT_B;
                end
                S_WAIT_B: begin
                    b_reg <= stk_data_out;
                    // Empty after popping b means only one operand existed.
                    if (stk_empty) begin
                        state_reg <= S_ERR;
                        error     <= 1'b1;
                    end else begin
                        state_reg <= S_POP_A;
                        stk_pop   <= 1'b1;
                    end
                end
                S_POP_A: begin
                    state_reg <= S_WAIT_A;
                end
                S_WAIT_A: begin
                    // Two pops precede this push, so the stack cannot be full.
                    a_reg        <= a_next;
                    state_reg    <= S_PUSH_R;
                    stk_push     <= 1'b1;
                    stk_data_in  <= alu_next;
                    result       <= alu_next;
                    result_valid <= 1'b1;
                end
                S_PUSH_R: begin
                    state_reg <= S_IDLE;
                    tok_ready <= 1'b1;
                end
                S_ERR: begin
                    if (clr) begin
                        state_reg <= S_IDLE;
                        error     <= 1'b0;
                        tok_ready <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    tok_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rpn_stack_master.sv
// -----------------------------------------------------------------------------
// tb_rpn_stack_master
//
// Bench for rpn_stack_master. It provides a behavioural 8-deep LIFO stack and
// checks every token against a queue-based RPN reference model. It runs the
// directed scenarios first and then a randomized token stream.
// -----------------------------------------------------------------------------
module tb_rpn_stack_master;

    localparam int W = 4;
    localparam int DEPTH = 8;

    logic         clk = 1'b0;
    logic         rstN = 1'b0;
    logic         clr = 1'b0;
    logic         tok_valid = 1'b0;
    logic         tok_ready;
    logic         tok_is_op = 1'b0;
    logic [W-1:0] tok_val = '0;
    logic         stk_push;
    logic         stk_pop;
    logic [W-1:0] stk_data_in;
    logic [W-1:0] stk_data_out;
    logic         stk_full;
    logic         stk_empty;
    logic [W-1:0] result;
    logic         result_valid;
    logic         error;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    rpn_stack_master #(.WIDTH(W)) dut (
        .clk          (clk),
        .rstN         (rstN),
        .clr          (clr),
        .tok_valid    (tok_valid),
        .tok_ready    (tok_ready),
        .tok_is_op    (tok_is_op),
        .tok_val      (tok_val),
        .stk_push     (stk_push),
        .stk_pop      (stk_pop),
        .stk_data_in  (stk_data_in),
        .stk_data_out (stk_data_out),
        .stk_full     (stk_full),
        .stk_empty    (stk_empty),
        .result       (result),
        .result_valid (result_valid),
        .error        (error)
    );

    // Behavioural LIFO stack with a registered pop output.
    logic [W-1:0] smem [DEPTH];
    int           scount;
    logic [W-1:0] sdout;

    assign stk_full     = (scount == DEPTH);
    assign stk_empty    = (scount == 0);
    assign stk_data_out = sdout;

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            scount <= 0;
            sdout  <= '0;
        end else if (stk_push && scount < DEPTH) begin
            smem[scount] <= stk_data_in;
            scount       <= scount + 1;
        end else if (stk_pop && scount > 0) begin
            sdout  <= smem[scount-1];
            scount <= scount - 1;
        end
    end

    // Strobe monitor: counts strobes and protocol violations.
    int           push_cnt = 0;
    int           pop_cnt = 0;
    int           rv_cnt = 0;
    int           viol_cnt = 0;
    logic [W-1:0] last_push = '0;

    always @(posedge clk) begin
        if (rstN) begin
            if (stk_push) begin
                push_cnt  <= push_cnt + 1;
                last_push <= stk_data_in;
            end
            if (stk_pop)      pop_cnt <= pop_cnt + 1;
            if (result_valid) rv_cnt  <= rv_cnt + 1;
            if ((stk_push && stk_pop) || (stk_push && stk_full) || (stk_pop && stk_empty))
                viol_cnt <= viol_cnt + 1;
        end
    end

    // Reference model state.
    int mq[$];
    int exp_result = 0;
    bit model_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_stack();
        check("stk_depth", scount, mq.size());
        for (int i = 0; i < mq.size(); i++) begin
            check("stk_entry", {28'd0, smem[i]}, mq[i]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstN = 1'b0;
        tok_valid = 1'b0;
        clr = 1'b0;
        #1;
        check("rst_tok_ready", tok_ready, 1);
        check("rst_error", error, 0);
        check("rst_result", result, 0);
        check("rst_strobes", {stk_push, stk_pop, result_valid}, 0);
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        mq.delete();
        exp_result = 0;
        model_err = 1'b0;
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        check("clr_error", error, 0);
        check("clr_tok_ready", tok_ready, 1);
        model_err = 1'b0;
    endtask

    // Presents one token, waits for the controller to settle, and compares
    // against the RPN model.
    task automatic send_token(input bit is_op, input int val);
        int n;
        int p0, q0, r0;
        int e_push, e_pop, e_rv, e_last, opc, a, b, r;
        bit e_err;
        n = 0;
        while (tok_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", (n < 20), 1);
        p0 = push_cnt; q0 = pop_cnt; r0 = rv_cnt;
        tok_is_op = is_op;
        tok_val   = val[W-1:0];
        tok_valid = 1'b1;
        @(posedge clk);
        #1 tok_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(tok_ready === 1'b1 || error === 1'b1) && n < 20);
        check("done_timeout", (n < 20), 1);

        e_push = 0; e_pop = 0; e_rv = 0; e_last = 0; e_err = 1'b0;
        if (!is_op) begin
            if (mq.size() == DEPTH) e_err = 1'b1;
            else begin
                mq.push_back(val % 16);
                e_push = 1;
                e_last = val % 16;
            end
        end else begin
            opc = val % 8;
            if (opc > 4 || mq.size() == 0) e_err = 1'b1;
            else if (mq.size() == 1) begin
                void'(mq.pop_back());
                e_pop = 1;
                e_err = 1'b1;
            end else begin
                b = mq.pop_back();
                a = mq.pop_back();
                case (opc)
                    0:       r = (a + b) % 16;
                    1:       r = (a - b + 16) % 16;
                    2:       r = a & b;
                    3:       r = a | b;
                    default: r = a ^ b;
                endcase
                mq.push_back(r);
                e_push = 1; e_pop = 2; e_rv = 1; e_last = r;
                exp_result = r;
            end
        end
        model_err = e_err;

        $display("token op=%0d val=%0d : err=%0d result=%0d depth=%0d",
                 is_op, val, error, result, scount);
        check("error", error, e_err);
        check("tok_ready", tok_ready, !e_err);
        check("push_count", push_cnt - p0, e_push);
        check("pop_count", pop_cnt - q0, e_pop);
        check("rv_count", rv_cnt - r0, e_rv);
        check("result", result, exp_result);
        check("violations", viol_cnt, 0);
        if (e_push != 0) check("push_value", last_push, e_last);
        check_stack();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, q0, r0, n;
        // 1: 3 4 ADD
        do_reset();
        send_token(0, 3);
        send_token(0, 4);
        send_token(1, 0);
        // 2: 5 9 SUB -> 12, then 12 XOR -> 0
        send_token(0, 5);
        send_token(0, 9);
        send_token(1, 1);
        send_token(0, 12);
        send_token(1, 4);

        // 3: ADD on empty stack, tokens offered during ERR are ignored
        do_reset();
        send_token(1, 0);
        p0 = push_cnt; q0 = pop_cnt;
        tok_is_op = 1'b0; tok_val = 4'd5; tok_valid = 1'b1;
        repeat (3) @(negedge clk);
        tok_valid = 1'b0;
        check("err_hold_error", error, 1);
        check("err_hold_ready", tok_ready, 0);
        check("err_hold_strobes", (push_cnt - p0) + (pop_cnt - q0), 0);
        check_stack();
        do_clr();

        // 4: single-operand AND underflow, then invalid opcode 7
        send_token(0, 6);
        send_token(1, 2);
        do_clr();
        send_token(0, 2);
        send_token(0, 11);
        send_token(1, 7);
        do_clr();

        // 5: fill to 8 entries, 9th operand overflows
        do_reset();
        for (int i = 1; i <= 8; i++) send_token(0, i);
        check("full_flag", stk_full, 1);
        send_token(0, 9);
        do_clr();

        // 6: asynchronous reset during POP_A of 3 4 ADD
        do_reset();
        send_token(0, 3);
        send_token(0, 4);
        tok_is_op = 1'b1; tok_val = 4'd0; tok_valid = 1'b1;
        @(posedge clk);
        #1 tok_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("pop_a_strobe", stk_pop, 1);
        rstN = 1'b0;
        #1;
        check("arst_tok_ready", tok_ready, 1);
        check("arst_outputs", {stk_push, stk_pop, stk_data_in, result, result_valid, error}, 0);
        @(negedge clk);
        rstN = 1'b1;
        mq.delete();
        exp_result = 0;
        model_err = 1'b0;
        r0 = rv_cnt;
        repeat (3) @(negedge clk);
        check("post_rst_ready", tok_ready, 1);
        check("post_rst_no_rv", rv_cnt - r0, 0);
        check_stack();

        // Randomized token stream
        do_reset();
        for (int t = 0; t < 300; t++) begin
            if (model_err) do_clr();
            n = $urandom_range(0, 99);
            if (mq.size() < 2 ? (n < 80) : (n < 45)) begin
                send_token(0, $urandom_range(0, 15));
            end else if (n < 95) begin
                send_token(1, $urandom_range(0, 4) + 8 * $urandom_range(0, 1));
            end else begin
                send_token(1, $urandom_range(5, 7));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
